// File: rtl/tmr_pkg.sv
// Shared types and constants for the 8-bit timer channel counter/control unit.
package tmr_pkg;

   typedef enum logic [2:0] {
      CKS_STOP     = 3'b000,
      CKS_DIV1     = 3'b001,
      CKS_DIV8     = 3'b010,
      CKS_DIV64    = 3'b011,
      CKS_DIV8192  = 3'b100,
      CKS_EXT_RISE = 3'b101,
      CKS_EXT_FALL = 3'b110,
      CKS_EXT_BOTH = 3'b111
   } cks_e;

   typedef enum logic [1:0] {
      CCLR_NONE = 2'b00,
      CCLR_CMA  = 2'b01,
      CCLR_CMB  = 2'b10,
      CCLR_TMRI = 2'b11
   } cclr_e;

   // Encoding order doubles as merge priority when A and B match together.
   typedef enum logic [1:0] {
      OS_NONE = 2'b00,
      OS_CLR  = 2'b01,
      OS_SET  = 2'b10,
      OS_TGL  = 2'b11
   } os_act_e;

   localparam int TAP_DIV1    = 0;
   localparam int TAP_DIV8    = 3;
   localparam int TAP_DIV64   = 6;
   localparam int TAP_DIV8192 = 13;

   localparam int IRQ_OVI  = 0;
   localparam int IRQ_CMIA = 1;
   localparam int IRQ_CMIB = 2;

   function automatic os_act_e os_merge(input os_act_e a, input os_act_e b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/tmr_edge_sync.sv
// Two-flop synchronizer for an asynchronous pin, plus single-cycle rise/fall pulses.
module tmr_edge_sync (
   input  logic i_clk_sys,
   input  logic i_rst_n,
   input  logic i_async,
   output logic o_rise,
   output logic o_fall
);

   logic meta, sync, prev;

   always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
      if (!i_rst_n) begin
         meta <= 1'b0;
         sync <= 1'b0;
         prev <= 1'b0;
      end else begin
         meta <= i_async;
         sync <= meta;
         prev <= sync;
      end
   end

   assign o_rise = sync & ~prev;
   assign o_fall = ~sync & prev;

endmodule

// File: rtl/tmr_count_ctrl.sv
// Timer channel counter/control: clock select, TCNT with clear modes, compare/overflow
// events, output-pin actions, ADC trigger and interrupt gating.
module tmr_count_ctrl
   import tmr_pkg::*;
#(
   parameter int CNT_WIDTH = 8,
   parameter int PSC_WIDTH = 13
) (
   input  logic                 i_clk_sys,
   input  logic                 i_rst_n,
   input  logic [2:0]           i_cks,
   input  logic [1:0]           i_cclr,
   input  logic                 i_tmci,
   input  logic                 i_tmri,
   input  logic                 i_tcnt_wren,
   input  logic [CNT_WIDTH-1:0] i_tcnt_wdata,
   input  logic [CNT_WIDTH-1:0] i_tcora,
   input  logic [CNT_WIDTH-1:0] i_tcorb,
   input  logic [3:0]           i_os,
   input  logic                 i_atde,
   input  logic [2:0]           i_flags,
   input  logic [2:0]           i_ie,
   output logic [CNT_WIDTH-1:0] o_tcnt,
   output logic                 o_overflow,
   output logic                 o_cma,
   output logic                 o_cmb,
   output logic                 o_tmo,
   output logic                 o_adc_trig,
   output logic [2:0]           o_irq
);

   logic [PSC_WIDTH-1:0] psc;
   logic [CNT_WIDTH-1:0] tcnt, tcnt_nxt;
   logic                 tmci_rise, tmci_fall, tmri_rise, tmri_fall_unused;
   logic                 tick, eq_a, eq_b, tmri_clr, cmp_clr;
   logic                 match_a, match_b, ovf;
   os_act_e              act;
   logic                 tmo_nxt;
   cclr_e                cclr;

   assign cclr = cclr_e'(i_cclr);

   tmr_edge_sync u_sync_tmci (
      .i_clk_sys (i_clk_sys),
      .i_rst_n   (i_rst_n),
      .i_async   (i_tmci),
      .o_rise    (tmci_rise),
      .o_fall    (tmci_fall)
   );

   tmr_edge_sync u_sync_tmri (
      .i_clk_sys (i_clk_sys),
      .i_rst_n   (i_rst_n),
      .i_async   (i_tmri),
      .o_rise    (tmri_rise),
      .o_fall    (tmri_fall_unused)
   );

   // Prescaler never restarts on a clock-select change, so tick phase is preserved.
   always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
      if (!i_rst_n) psc <= '0;
      else          psc <= psc + 1'b1;
   end

   always_comb begin
      tick = 1'b0;
      case (cks_e'(i_cks))
         CKS_STOP:     tick = 1'b0;
         CKS_DIV1:     tick = 1'b1;
         CKS_DIV8:     tick = &psc[TAP_DIV8-1:0];
         CKS_DIV64:    tick = &psc[TAP_DIV64-1:0];
         CKS_DIV8192:  tick = &psc[TAP_DIV8192-1:0];
         CKS_EXT_RISE: tick = tmci_rise;
         CKS_EXT_FALL: tick = tmci_fall;
         CKS_EXT_BOTH: tick = tmci_rise | tmci_fall;
         default:      tick = 1'b0;
      endcase
   end

   assign eq_a     = (tcnt == i_tcora);
   assign eq_b     = (tcnt == i_tcorb);
   assign tmri_clr = (cclr == CCLR_TMRI) && tmri_rise;
   assign cmp_clr  = tick && (((cclr == CCLR_CMA) && eq_a) || ((cclr == CCLR_CMB) && eq_b));
   assign match_a  = tick & eq_a & ~i_tcnt_wren;
   assign match_b  = tick & eq_b & ~i_tcnt_wren;
   assign ovf      = tick & (&tcnt) & ~i_tcnt_wren & ~tmri_clr & ~cmp_clr;

   always_comb begin
      tcnt_nxt = tcnt;
      if (i_tcnt_wren)             tcnt_nxt = i_tcnt_wdata;
      else if (tmri_clr || cmp_clr) tcnt_nxt = '0;
      else if (tick)               tcnt_nxt = tcnt + 1'b1;
   end

   always_comb begin
      act = os_merge(match_a ? os_act_e'(i_os[1:0]) : OS_NONE,
                     match_b ? os_act_e'(i_os[3:2]) : OS_NONE);
      tmo_nxt = o_tmo;
      case (act)
         OS_CLR:  tmo_nxt = 1'b0;
         OS_SET:  tmo_nxt = 1'b1;
         OS_TGL:  tmo_nxt = ~o_tmo;
         default: tmo_nxt = o_tmo;
      endcase
   end

   always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
      if (!i_rst_n) begin
         tcnt       <= '0;
         o_overflow <= 1'b0;
         o_cma      <= 1'b0;
         o_cmb      <= 1'b0;
         o_adc_trig <= 1'b0;
         o_tmo      <= 1'b0;
      end else begin
         tcnt       <= tcnt_nxt;
         o_overflow <= ovf;
         o_cma      <= match_a;
         o_cmb      <= match_b;
         o_adc_trig <= match_a & i_atde;
         o_tmo      <= tmo_nxt;
      end
   end

   assign o_tcnt = tcnt;

   assign o_irq[IRQ_OVI]  = i_flags[IRQ_OVI]  & i_ie[IRQ_OVI];
   assign o_irq[IRQ_CMIA] = i_flags[IRQ_CMIA] & i_ie[IRQ_CMIA];
   assign o_irq[IRQ_CMIB] = i_flags[IRQ_CMIB] & i_ie[IRQ_CMIB];

endmodule

// File: tb/tb_tmr_count_ctrl.sv
// Directed bench for tmr_count_ctrl with hand-computed expectations.
module tb_tmr_count_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [2:0] cks;
   logic [1:0] cclr;
   logic       tmci, tmri, wren;
   logic [7:0] wdata, tcora, tcorb;
   logic [3:0] os;
   logic       atde;
   logic [2:0] flags, ie;
   logic [7:0] tcnt;
   logic       ovf, cma, cmb, tmo, adc;
   logic [2:0] irq;

   int errors = 0;
   int checks = 0;

   tmr_count_ctrl dut (
      .i_clk_sys    (clk),
      .i_rst_n      (rst_n),
      .i_cks        (cks),
      .i_cclr       (cclr),
      .i_tmci       (tmci),
      .i_tmri       (tmri),
      .i_tcnt_wren  (wren),
      .i_tcnt_wdata (wdata),
      .i_tcora      (tcora),
      .i_tcorb      (tcorb),
      .i_os         (os),
      .i_atde       (atde),
      .i_flags      (flags),
      .i_ie         (ie),
      .o_tcnt       (tcnt),
      .o_overflow   (ovf),
      .o_cma        (cma),
      .o_cmb        (cmb),
      .o_tmo        (tmo),
      .o_adc_trig   (adc),
      .o_irq        (irq)
   );

   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic write_tcnt(input logic [7:0] v);
      wren  = 1'b1;
      wdata = v;
      step(1);
      wren  = 1'b0;
   endtask

   initial begin
      int n_cma, n_ovf;
      bit found;
      rst_n = 1'b0; cks = 3'b000; cclr = 2'b00; tmci = 1'b0; tmri = 1'b0;
      wren = 1'b0; wdata = 8'h00; tcora = 8'h00; tcorb = 8'h00; os = 4'b0000;
      atde = 1'b0; flags = 3'b101; ie = 3'b111;
      #12;
      chk("rst_tcnt", tcnt, 8'h00);
      chk("rst_events", {ovf, cma, cmb, adc, tmo}, 5'b0);
      chk("irq_all_en", irq, 3'b101);
      ie = 3'b011; #1;
      chk("irq_masked", irq, 3'b001);

      // Clear on CMA at 5, toggling output
      cks = 3'b001; cclr = 2'b01; tcora = 8'h05; os = 4'b0011;
      rst_n = 1'b1;
      step(5);
      chk("cma_pre_tcnt", tcnt, 8'h05);
      chk("cma_pre_pulse", cma, 1'b0);
      step(1);
      chk("cma1_tcnt", tcnt, 8'h00);
      chk("cma1_pulse", cma, 1'b1);
      chk("cma1_tmo", tmo, 1'b1);
      step(1);
      chk("cma1_width", cma, 1'b0);
      chk("cma1_next", tcnt, 8'h01);
      step(5);
      chk("cma2_pulse", cma, 1'b1);
      chk("cma2_tmo", tmo, 1'b0);
      n_cma = 0; n_ovf = 0;
      for (int i = 0; i < 12; i++) begin
         step(1);
         n_cma += int'(cma);
         n_ovf += int'(ovf);
      end
      chk("cma_period_count", n_cma, 2);
      chk("cma_no_ovf", n_ovf, 0);

      // Overflow wrap from 0xFD
      cclr = 2'b00;
      write_tcnt(8'hFD);
      chk("wr_fd", tcnt, 8'hFD);
      step(2);
      chk("ovf_at_ff", tcnt, 8'hFF);
      chk("ovf_not_yet", ovf, 1'b0);
      step(1);
      chk("ovf_wrap", tcnt, 8'h00);
      chk("ovf_pulse", ovf, 1'b1);
      step(1);
      chk("ovf_width", ovf, 1'b0);

      // Clear at 0xFF preempts overflow
      cclr = 2'b01; tcora = 8'hFF;
      write_tcnt(8'hFD);
      step(3);
      chk("clr_ff_tcnt", tcnt, 8'h00);
      chk("clr_ff_noovf", ovf, 1'b0);
      chk("clr_ff_cma", cma, 1'b1);

      // Prescaler /8, stop, resume without phase reset
      cks = 3'b000; cclr = 2'b00; os = 4'b0000;
      write_tcnt(8'h00);
      cks = 3'b010;
      found = 1'b0;
      for (int i = 0; i < 16; i++) begin
         step(1);
         if (tcnt != 8'h00) begin
            found = 1'b1;
            break;
         end
      end
      chk("div8_first_tick", found, 1'b1);
      chk("div8_first_val", tcnt, 8'h01);
      step(7);
      chk("div8_hold", tcnt, 8'h01);
      step(1);
      chk("div8_second", tcnt, 8'h02);
      cks = 3'b000;
      step(20);
      chk("stop_frozen", tcnt, 8'h02);
      cks = 3'b010;
      step(3);
      chk("resume_hold", tcnt, 8'h02);
      step(1);
      chk("resume_phase", tcnt, 8'h03);

      // Simultaneous A/B match, output priority and ADC trigger
      cks = 3'b001; os = 4'b0010; tcora = 8'h10; tcorb = 8'h10;
      write_tcnt(8'h10);
      chk("wr_suppress_cma", cma, 1'b0);
      step(1);
      chk("ab1_pulses", {cma, cmb}, 2'b11);
      chk("ab1_tmo_set", tmo, 1'b1);
      chk("ab1_no_adc", adc, 1'b0);
      os = 4'b1101; atde = 1'b1;
      write_tcnt(8'h10);
      step(1);
      chk("ab2_pulses", {cma, cmb}, 2'b11);
      chk("ab2_tmo_tgl", tmo, 1'b0);
      chk("ab2_adc", adc, 1'b1);
      step(1);
      chk("ab2_adc_width", {adc, cma, cmb}, 3'b000);
      atde = 1'b0;

      // Write wins over match on the tick cycle
      os = 4'b0000; cclr = 2'b01; tcora = 8'h05;
      write_tcnt(8'h05);
      write_tcnt(8'h40);
      chk("wr_over_match_tcnt", tcnt, 8'h40);
      chk("wr_over_match_cma", cma, 1'b0);

      // External clock, rising edges only
      cks = 3'b101; cclr = 2'b00;
      write_tcnt(8'h00);
      tmci = 1'b1;
      step(2);
      chk("ext1_latency", tcnt, 8'h00);
      step(1);
      chk("ext1_count", tcnt, 8'h01);
      tmci = 1'b0;
      step(3);
      chk("ext_fall_ignored", tcnt, 8'h01);
      tmci = 1'b1;
      step(2);
      chk("ext2_latency", tcnt, 8'h01);
      step(1);
      chk("ext2_count", tcnt, 8'h02);
      tmci = 1'b0;
      step(3);
      chk("ext2_fall_ignored", tcnt, 8'h02);

      // External counter reset
      cclr = 2'b11; tmri = 1'b1;
      step(2);
      chk("tmri_latency", tcnt, 8'h02);
      step(1);
      chk("tmri_clear", tcnt, 8'h00);
      tmri = 1'b0;

      // Async reset mid-count
      cks = 3'b001; cclr = 2'b00; os = 4'b0010; tcora = 8'h03;
      step(5);
      chk("pre_rst_tcnt", tcnt, 8'h05);
      chk("pre_rst_tmo", tmo, 1'b1);
      #3 rst_n = 1'b0;
      #1;
      chk("async_rst_tcnt", tcnt, 8'h00);
      chk("async_rst_outs", {ovf, cma, cmb, adc, tmo}, 5'b0);
      #1 rst_n = 1'b1;
      step(1);
      chk("post_rst_tcnt", tcnt, 8'h01);
      chk("post_rst_events", {ovf, cma, cmb, adc, tmo}, 5'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
